// File: rtl/urv_dm_wb_bridge.sv
// Bridges the uRV data-memory port onto a pipelined Wishbone B4 master.
// One access in flight; bus errors and timeouts complete the access and are captured.
module urv_dm_wb_bridge #(
  parameter int unsigned g_timeout_cycles = 255,
  parameter logic [31:0] g_err_load_value = 32'hFFFFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [31:0] TMO_LAST = (g_timeout_cycles == 0) ? 32'd0 : g_timeout_cycles - 1;

  state_t      state, state_nxt;
  logic [31:0] byte_addr;
  logic [31:0] tmo_cnt;
  logic        accept, active, timeout, done, fail;

  assign dm_ready_o = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    accept    = dm_ready_o && (dm_load_i || dm_store_i);
    active    = (state == S_REQ) || (state == S_WAIT);
    // counter holds cycles already spent, so the abort edge is the T-th one after accept
    timeout   = active && (g_timeout_cycles != 0) && (tmo_cnt == TMO_LAST) && !wb_ack_i && !wb_err_i;
    done      = active && (wb_ack_i || wb_err_i || timeout);
    fail      = wb_err_i || timeout;
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? S_REQ : S_IDLE;
      S_REQ:          if (done) state_nxt = S_DONE;
                      else if (!wb_stall_i) state_nxt = S_WAIT;
      S_WAIT:         if (done) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byte_addr       <= '0;
      tmo_cnt         <= '0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      wb_sel_o        <= '0;
      wb_we_o         <= 1'b0;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_err_o       <= 1'b0;
      err_addr_o      <= '0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_err_o       <= 1'b0;
      if (accept) begin
        byte_addr <= dm_addr_i;
        wb_adr_o  <= {dm_addr_i[31:2], 2'b00};
        wb_dat_o  <= dm_data_s_i;
        wb_sel_o  <= dm_data_select_i;
        wb_we_o   <= dm_store_i;
        wb_cyc_o  <= 1'b1;
        wb_stb_o  <= 1'b1;
        tmo_cnt   <= '0;
      end else if (active) begin
        tmo_cnt <= tmo_cnt + 32'd1;
        if (state == S_REQ && !wb_stall_i) wb_stb_o <= 1'b0;
        if (done) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          if (wb_we_o) dm_store_done_o <= 1'b1;
          else begin
            dm_load_done_o <= 1'b1;
            dm_data_l_o    <= fail ? g_err_load_value : wb_dat_i;
          end
          if (fail) begin
            bus_err_o  <= 1'b1;
            err_addr_o <= byte_addr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Bench for urv_dm_wb_bridge: directed table, hand-written corner sequences, random traffic
// checked against a cycle-count model of the access rules.
module tb_urv_dm_wb_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dm_addr = '0, dm_data_s = '0, wb_dat_i = '0;
  logic [3:0]  dm_sel = '0;
  logic        dm_store = 1'b0, dm_load = 1'b0;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic        dm_ready, dm_load_done, dm_store_done, wb_we, wb_cyc, wb_stb, bus_err;
  logic [31:0] dm_data_l, wb_adr, wb_dat_o, err_addr;
  logic [3:0]  wb_sel;

  int nvec = 0, nfail = 0;
  logic [31:0] last_dl = '0, last_ea = '0;

  always #5 clk = ~clk;

  urv_dm_wb_bridge #(.g_timeout_cycles(T), .g_err_load_value(32'hFFFFFFFF)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_store_i(dm_store), .dm_load_i(dm_load), .dm_ready_o(dm_ready),
    .dm_data_l_o(dm_data_l), .dm_load_done_o(dm_load_done), .dm_store_done_o(dm_store_done),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_stall_i(wb_stall),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .bus_err_o(bus_err), .err_addr_o(err_addr)
  );

  // resp: 0 ack, 1 err, 2 ack+err, 3 no response
  typedef struct {
    logic        st;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          stall_n, dly, resp;
    logic [31:0] rd;
    int          exp_d;
    logic        exp_err;
    logic [31:0] exp_dl, exp_ea;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int got_d = -1, lcnt = 0, scnt = 0, stb_cnt = 0, cyc_cnt = 0, rc, exp_stb;
    rc = v.stall_n + 1 + v.dly;
    exp_stb = (v.stall_n + 1 < v.exp_d) ? v.stall_n + 1 : v.exp_d;
    @(negedge clk);
    chk("ready_before_req", {31'd0, dm_ready}, 32'd1);
    dm_addr = v.a; dm_data_s = v.d; dm_sel = v.s;
    dm_store = v.st; dm_load = ~v.st;
    @(posedge clk); #1;
    dm_store = 1'b0; dm_load = 1'b0;
    chk("acc_adr", wb_adr, {v.a[31:2], 2'b00});
    chk("acc_sel_we", {27'd0, wb_sel, wb_we}, {27'd0, v.s, v.st});
    chk("acc_dat", wb_dat_o, v.d);
    chk("acc_ctl", {26'd0, wb_cyc, wb_stb, dm_ready, dm_load_done, dm_store_done, bus_err},
        32'b110000);
    for (int c = 1; c <= 40; c++) begin
      if (wb_stb) stb_cnt++;
      if (wb_cyc) cyc_cnt++;
      wb_dat_i = v.rd;
      wb_stall = (c <= v.stall_n);
      wb_ack = (v.resp == 0 || v.resp == 2) && (c == rc);
      wb_err = (v.resp == 1 || v.resp == 2) && (c == rc);
      @(posedge clk); #1;
      wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
      if (dm_load_done) lcnt++;
      if (dm_store_done) scnt++;
      if (dm_load_done || dm_store_done) begin
        got_d = c;
        break;
      end
    end
    chk("done_latency", got_d, v.exp_d);
    chk("done_kind", {lcnt[15:0], scnt[15:0]}, v.st ? 32'h0000_0001 : 32'h0001_0000);
    chk("stb_cycles", stb_cnt, exp_stb);
    chk("cyc_cycles", cyc_cnt, v.exp_d);
    chk("bus_err", {31'd0, bus_err}, {31'd0, v.exp_err});
    chk("done_ctl", {29'd0, dm_ready, wb_cyc, wb_stb}, 32'b100);
    chk("load_data", dm_data_l, v.exp_dl);
    chk("err_addr", err_addr, v.exp_ea);
  endtask

  // Expected outcome from the access rules: response edge vs timeout edge, counted from accept.
  task automatic run_model(input logic st, input logic [31:0] a, d, input logic [3:0] s,
                           input int stall_n, dly, resp, input logic [31:0] rd);
    vec_t v;
    int rc;
    v.st = st; v.a = a; v.d = d; v.s = s; v.stall_n = stall_n; v.dly = dly;
    v.resp = resp; v.rd = rd;
    rc = stall_n + 1 + dly;
    if (resp == 3 || rc > T) begin
      v.exp_d = T; v.exp_err = 1'b1;
    end else begin
      v.exp_d = rc; v.exp_err = (resp != 0);
    end
    if (!st) last_dl = v.exp_err ? 32'hFFFFFFFF : rd;
    if (v.exp_err) last_ea = a;
    v.exp_dl = last_dl; v.exp_ea = last_ea;
    run_txn(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    tbl[0] = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 0, 1, 0, 32'h1234_5678, 2, 1'b0, 32'h1234_5678, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_2003, 32'hAABB_CCDD, 4'h8, 3, 1, 0, 32'h0,         5, 1'b0, 32'h1234_5678, 32'h0};
    tbl[2] = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, 0, 1, 1, 32'h5555_5555, 2, 1'b1, 32'hFFFF_FFFF, 32'h8000_0010};
    tbl[3] = '{1'b0, 32'h0000_3000, 32'h0,         4'h3, 0, 1, 3, 32'h0,         8, 1'b1, 32'hFFFF_FFFF, 32'h0000_3000};
    tbl[4] = '{1'b1, 32'h0000_4001, 32'h0102_0304, 4'h1, 1, 0, 2, 32'h0,         2, 1'b1, 32'hFFFF_FFFF, 32'h0000_4001};
    tbl[5] = '{1'b0, 32'h0000_5008, 32'h0,         4'hC, 2, 0, 0, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 32'h0000_4001};

    #2;
    chk("rst_ready", {31'd0, dm_ready}, 32'd1);
    chk("rst_ctl", {25'd0, wb_cyc, wb_stb, wb_we, dm_load_done, dm_store_done, bus_err, 1'b0}, 32'd0);
    chk("rst_regs", wb_adr | wb_dat_o | {28'd0, wb_sel} | dm_data_l | err_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back: each entry is issued in the done cycle of the previous one
    foreach (tbl[i]) run_txn(tbl[i]);
    last_dl = 32'hCAFE_F00D; last_ea = 32'h0000_4001;

    // timeout followed by a stray ack two cycles later
    run_model(1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 0, 3, 32'h0);
    @(posedge clk); #1;
    wb_ack = 1'b1; wb_dat_i = 32'h7777_7777;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (dm_load_done || dm_store_done || bus_err || wb_cyc || !dm_ready) bad++;
      @(posedge clk); #1;
    end
    chk("late_ack_ignored", bad, 0);
    chk("late_ack_data", dm_data_l, 32'hFFFF_FFFF);

    // reset while waiting for ack on a store
    @(negedge clk);
    dm_addr = 32'h0000_7004; dm_data_s = 32'h1111_2222; dm_sel = 4'hF; dm_store = 1'b1;
    @(posedge clk); #1;
    dm_store = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_wait", {30'd0, wb_cyc, wb_stb}, 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {28'd0, wb_cyc, wb_stb, wb_we, dm_ready}, 32'b0001);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (dm_load_done || dm_store_done || bus_err || wb_cyc) bad++;
    end
    chk("no_done_after_rst", bad, 0);
    chk("rst_clears_data", dm_data_l | err_addr, 32'd0);
    last_dl = '0; last_ea = '0;
    run_model(1'b0, 32'h0000_1008, 32'h0, 4'hF, 0, 1, 0, 32'h0BAD_F00D);

    // randomized traffic, including responses that land on or past the timeout edge
    for (int n = 0; n < 40; n++) begin
      int r, resp;
      r = $urandom_range(0, 7);
      resp = (r <= 4) ? 0 : r - 4;
      run_model(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
                $urandom_range(0, 6), $urandom_range(0, 3), resp, $urandom);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
